imm_ext_pipe: RTL

//  Registered, flow-controlled immediate generator for the decode stage. It is the parametrised successor of the

---
 rtl/imm_ext_pipe.sv | 94 +++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// Registered, flow-controlled immediate generator: decode into a main output register backed by a skid register.
// Optional build macro IMM_EXT_ZICSR_EN enables the CSR zimm format on imm_src 3'b110.
module imm_ext_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      instr,
   input  logic [2:0]       imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_ext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   // instr[k] holds instruction bit k+7
   logic [XLEN-1:0]  dec_imm;
   logic             dec_err;

   logic             skid_valid;
   logic [XLEN-1:0]  skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             skid_err;

   logic             accept;
   logic             main_free;

   always_comb begin
      dec_imm = '0;
      dec_err = 1'b0;
      case (imm_src)
         3'b000: dec_imm = XLEN'($signed(instr[24:13]));
         3'b001: dec_imm = XLEN'($signed({instr[24:18], instr[4:0]}));
         3'b010: dec_imm = XLEN'($signed({instr[24], instr[0], instr[23:18], instr[4:1], 1'b0}));
         3'b011: dec_imm = XLEN'($signed({instr[24], instr[12:5], instr[13], instr[23:14], 1'b0}));
         3'b100: dec_imm = XLEN'($signed({instr[24:5], 12'h000}));
         3'b101: dec_imm = (XLEN == 64) ? XLEN'(instr[18:13]) : XLEN'(instr[17:13]);
`ifdef IMM_EXT_ZICSR_EN
         3'b110: dec_imm = XLEN'(instr[12:8]);
`else
         3'b110: dec_err = 1'b1;
`endif
         default: dec_err = 1'b1;
      endcase
   end

   // in_ready is the inverse of a flop, so it never depends on out_ready combinationally
   assign in_ready  = ~skid_valid;
   assign accept    = in_valid & ~skid_valid;
   assign main_free = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         imm_ext    <= '0;
         out_tag    <= '0;
         out_err    <= 1'b0;
         skid_valid <= 1'b0;
         skid_imm   <= '0;
         skid_tag   <= '0;
         skid_err   <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            imm_ext    <= skid_imm;
            out_tag    <= skid_tag;
            out_err    <= skid_err;
            skid_valid <= 1'b0;
         end else begin
            out_valid <= accept;
            if (accept) begin
               imm_ext <= dec_imm;
               out_tag <= in_tag;
               out_err <= dec_err;
            end
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_imm   <= dec_imm;
         skid_tag   <= in_tag;
         skid_err   <= dec_err;
      end
   end

endmodule
